// File: rtl/player_datapath.sv
// Player ship datapath: holds the vertical position, applies saturating single-row moves,
// and turns the FSM's pixel offsets into registered absolute VGA pixel writes.
module player_datapath #(
  parameter logic [7:0] X_POS  = 8'd4,
  parameter logic [6:0] Y_INIT = 7'd56,
  parameter logic [6:0] Y_MIN  = 7'd0,
  parameter logic [6:0] Y_MAX  = 7'd117
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       y_pos_mod,
  input  logic       y_neg_mod,
  input  logic       add_x,
  input  logic [1:0] add_y,
  input  logic [2:0] colour_in,
  input  logic       write_en_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [6:0] player_y,
  output logic       at_top,
  output logic       at_bottom,
  output logic       move_done
);

  logic [6:0] y_next;
  logic       move_up;
  logic       move_down;

  assign move_up   = y_pos_mod && !y_neg_mod;
  assign move_down = y_neg_mod && !y_pos_mod;

  // Pixels issued alongside a move are addressed from the post-move row.
  always_comb begin
    y_next = player_y;
    if (move_up && (player_y > Y_MIN)) begin
      y_next = player_y - 7'd1;
    end else if (move_down && (player_y < Y_MAX)) begin
      y_next = player_y + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      player_y   <= Y_INIT;
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= 3'd0;
      plot       <= 1'b0;
      at_top     <= (Y_INIT == Y_MIN);
      at_bottom  <= (Y_INIT == Y_MAX);
      move_done  <= 1'b0;
    end else begin
      player_y   <= y_next;
      x_out      <= X_POS + {7'd0, add_x};
      y_out      <= y_next + {5'd0, add_y};
      colour_out <= colour_in;
      plot       <= write_en_in && (add_y != 2'b11);
      at_top     <= (y_next == Y_MIN);
      at_bottom  <= (y_next == Y_MAX);
      move_done  <= (y_next != player_y);
    end
  end

endmodule

// File: tb/tb_player_datapath.sv
// Directed bench for player_datapath: a vector table for the draw/offset cases plus
// hand-written sequences for saturation, simultaneous moves and mid-sequence reset.
module tb_player_datapath;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       y_pos_mod, y_neg_mod, add_x, write_en_in;
  logic [1:0] add_y;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic [6:0] player_y;
  logic       at_top, at_bottom, move_done;

  int checks = 0;
  int errors = 0;

  player_datapath dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .y_pos_mod  (y_pos_mod),
    .y_neg_mod  (y_neg_mod),
    .add_x      (add_x),
    .add_y      (add_y),
    .colour_in  (colour_in),
    .write_en_in(write_en_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .player_y   (player_y),
    .at_top     (at_top),
    .at_bottom  (at_bottom),
    .move_done  (move_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up, dn, ax;
    logic [1:0] ay;
    logic [2:0] col;
    logic       we;
    int         ex, ey, ecol, eplot, epy, emd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle past the edge.
  task automatic cyc(input logic up, input logic dn, input logic ax, input logic [1:0] ay,
                     input logic [2:0] col, input logic we);
    y_pos_mod   = up;
    y_neg_mod   = dn;
    add_x       = ax;
    add_y       = ay;
    colour_in   = col;
    write_en_in = we;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    //          up dn ax ay col we   x  y  col plot py md
    vecs[0] = '{1, 0, 0, 0, 0, 1,    4, 55, 0, 1, 55, 1};
    vecs[1] = '{0, 0, 1, 0, 0, 1,    5, 55, 0, 1, 55, 0};
    vecs[2] = '{0, 0, 0, 1, 7, 1,    4, 56, 7, 1, 55, 0};
    vecs[3] = '{0, 0, 1, 1, 7, 1,    5, 56, 7, 1, 55, 0};
    vecs[4] = '{0, 0, 0, 2, 0, 1,    4, 57, 0, 1, 55, 0};
    vecs[5] = '{0, 0, 1, 2, 0, 1,    5, 57, 0, 1, 55, 0};
    vecs[6] = '{1, 1, 0, 0, 3, 1,    4, 55, 3, 1, 55, 0};
    vecs[7] = '{0, 0, 1, 3, 5, 1,    5, 58, 5, 0, 55, 0};
    vecs[8] = '{0, 1, 0, 0, 0, 0,    4, 56, 0, 0, 56, 1};
    vecs[9] = '{0, 0, 1, 2, 6, 1,    5, 58, 6, 1, 56, 0};

    reset_n = 1'b0;
    do_reset();
    chk("reset player_y", player_y, 56);
    chk("reset plot", plot, 0);
    chk("reset x_out", x_out, 0);
    chk("reset y_out", y_out, 0);
    chk("reset colour_out", colour_out, 0);
    chk("reset move_done", move_done, 0);
    chk("reset at_top", at_top, 0);
    chk("reset at_bottom", at_bottom, 0);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].up, vecs[i].dn, vecs[i].ax, vecs[i].ay, vecs[i].col, vecs[i].we);
      chk($sformatf("vec%0d x_out", i), x_out, vecs[i].ex);
      chk($sformatf("vec%0d y_out", i), y_out, vecs[i].ey);
      chk($sformatf("vec%0d colour_out", i), colour_out, vecs[i].ecol);
      chk($sformatf("vec%0d plot", i), plot, vecs[i].eplot);
      chk($sformatf("vec%0d player_y", i), player_y, vecs[i].epy);
      chk($sformatf("vec%0d move_done", i), move_done, vecs[i].emd);
      chk($sformatf("vec%0d at_top", i), at_top, 0);
      chk($sformatf("vec%0d at_bottom", i), at_bottom, 0);
    end

    // Top saturation: 60 up moves from 56.
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk($sformatf("up%0d player_y", i), player_y, (i <= 56) ? 56 - i : 0);
      chk($sformatf("up%0d move_done", i), move_done, (i <= 56) ? 1 : 0);
    end
    chk("top at_top", at_top, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("top+down player_y", player_y, 1);
    chk("top+down at_top", at_top, 0);
    chk("top+down move_done", move_done, 1);

    // Bottom saturation: 116 moves to 117, then 3 more.
    for (int i = 0; i < 119; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("bottom player_y", player_y, 117);
    chk("bottom at_bottom", at_bottom, 1);
    chk("bottom move_done", move_done, 0);
    cyc(0, 0, 1, 2, 4, 1);
    chk("bottom pix x_out", x_out, 5);
    chk("bottom pix y_out", y_out, 119);
    chk("bottom pix plot", plot, 1);

    // Simultaneous up and down at y = 40.
    for (int i = 0; i < 77; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("pre-both player_y", player_y, 40);
    cyc(1, 1, 0, 0, 2, 1);
    chk("both player_y", player_y, 40);
    chk("both move_done", move_done, 0);
    chk("both x_out", x_out, 4);
    chk("both y_out", y_out, 40);
    chk("both plot", plot, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("both plot drop", plot, 0);

    // Reset during the 3rd pixel of a down sequence from y = 10.
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("pre-rst player_y", player_y, 10);
    cyc(0, 1, 0, 0, 1, 1);
    chk("seq p1 y_out", y_out, 11);
    chk("seq p1 plot", plot, 1);
    cyc(0, 0, 1, 0, 1, 1);
    chk("seq p2 x_out", x_out, 5);
    chk("seq p2 y_out", y_out, 11);
    reset_n = 1'b0;
    cyc(0, 0, 0, 1, 1, 1);
    reset_n = 1'b1;
    chk("mid-rst plot", plot, 0);
    chk("mid-rst player_y", player_y, 56);
    chk("mid-rst y_out", y_out, 0);
    cyc(0, 0, 0, 1, 1, 1);
    chk("resume plot", plot, 1);
    chk("resume y_out", y_out, 57);
    chk("resume colour_out", colour_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
